regfile_rob: RTL and testbench

REGFILE_ROB -- requirements
Module: regfile_rob

---
 rtl/regfile_rob_if.sv | 46 ++++
 rtl/regfile_rob.sv | 112 +++++++++++
 tb/tb_regfile_rob.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_rob_if.sv
// regfile_rob_if -- bundle of the register-file / reorder-buffer scoreboard bus.
//
// Groups everything except clk and rst:
//   rdy                      global ready; low freezes all state
//   rd_en/rd_addr            NRP packed read ports (port k in slice k)
//   rd_data/rd_busy/rd_tag   combinational read results per port
//   iss_en/iss_addr/iss_tag  issue: mark destination busy with a ROB tag
//   cmt_en/cmt_addr/cmt_data/cmt_tag  commit: write back a result
//   flush                    mispredict flush of all pending busy state
//   busy_cnt                 registered number of busy registers
//
// master drives requests (core / testbench); slave is the register file.
interface regfile_rob_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int TW   = 4,
    parameter int NRP  = 2
);
    logic                 rdy;
    logic [NRP-1:0]       rd_en;
    logic [NRP*AW-1:0]    rd_addr;
    logic [NRP*XLEN-1:0]  rd_data;
    logic [NRP-1:0]       rd_busy;
    logic [NRP*TW-1:0]    rd_tag;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic [TW-1:0]        iss_tag;
    logic                 cmt_en;
    logic [AW-1:0]        cmt_addr;
    logic [XLEN-1:0]      cmt_data;
    logic [TW-1:0]        cmt_tag;
    logic                 flush;
    logic [AW:0]          busy_cnt;

    modport master (
        output rdy, rd_en, rd_addr, iss_en, iss_addr, iss_tag,
               cmt_en, cmt_addr, cmt_data, cmt_tag, flush,
        input  rd_data, rd_busy, rd_tag, busy_cnt
    );

    modport slave (
        input  rdy, rd_en, rd_addr, iss_en, iss_addr, iss_tag,
               cmt_en, cmt_addr, cmt_data, cmt_tag, flush,
        output rd_data, rd_busy, rd_tag, busy_cnt
    );
endinterface

// File: rtl/regfile_rob.sv
// regfile_rob -- architectural register file with per-register busy/tag
// scoreboard for a reorder-buffer based out-of-order core.
//
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset, highest priority
//   bus  regfile_rob_if.slave: read ports, issue, commit, flush, busy_cnt
//
// Register 0 reads as zero and ignores issue/commit. Commits always write
// data but only release the busy bit when their tag matches the pending
// producer. Reads are combinational and bypass a same-cycle commit.
module regfile_rob #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int TW   = 4,
    parameter int NRP  = 2
) (
    input  logic          clk,
    input  logic          rst,
    regfile_rob_if.slave  bus
);

    logic [XLEN-1:0] data_q [NREG];
    logic [XLEN-1:0] data_d [NREG];
    logic [TW-1:0]   tag_q  [NREG];
    logic [TW-1:0]   tag_d  [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     busy_cnt_q;
    logic [AW:0]     busy_cnt_d;

    // Next-state: commit first, then issue overrides busy/tag of the same
    // register, then flush overrides every busy/tag. Data is never touched
    // by issue or flush. Register 0 is skipped entirely.
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if (bus.cmt_en && bus.cmt_addr == AW'(i)) begin
                data_d[i] = bus.cmt_data;
                if (busy_q[i] && tag_q[i] == bus.cmt_tag) begin
                    busy_d[i] = 1'b0;
                end
            end
            if (bus.iss_en && bus.iss_addr == AW'(i)) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = bus.iss_tag;
            end
            if (bus.flush) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Counting the next busy vector lets busy_cnt be a plain register that
    // always agrees with the busy bits after the edge.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else if (bus.rdy) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Read ports show pre-edge state; only a same-cycle commit is bypassed,
    // releasing busy when its tag would match. Addresses at or above NREG
    // read as zero.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        bus.rd_tag  = '0;
        for (int k = 0; k < NRP; k++) begin
            for (int i = 1; i < NREG; i++) begin
                if (bus.rd_en[k] && bus.rd_addr[k*AW +: AW] == AW'(i)) begin
                    bus.rd_data[k*XLEN +: XLEN] = data_q[i];
                    bus.rd_busy[k]              = busy_q[i];
                    bus.rd_tag[k*TW +: TW]      = tag_q[i];
                    if (bus.cmt_en && bus.cmt_addr == AW'(i)) begin
                        bus.rd_data[k*XLEN +: XLEN] = bus.cmt_data;
                        if (busy_q[i] && tag_q[i] == bus.cmt_tag) begin
                            bus.rd_busy[k] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign bus.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_rob.sv
// tb_regfile_rob -- directed self-checking bench for regfile_rob.
// Inputs change 1ns after each rising edge; combinational reads are
// sampled a further 1ns later, well away from the next edge.
module tb_regfile_rob;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    regfile_rob_if #(.XLEN(32), .AW(5), .TW(4), .NRP(2)) bus ();

    regfile_rob #(.XLEN(32), .NREG(32), .AW(5), .TW(4), .NRP(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, required finish before 200000");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle inputs with rdy high; reads disabled.
    task automatic clearInputs();
        bus.rdy      = 1'b1;
        bus.rd_en    = '0;
        bus.rd_addr  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.iss_tag  = '0;
        bus.cmt_en   = 1'b0;
        bus.cmt_addr = '0;
        bus.cmt_data = '0;
        bus.cmt_tag  = '0;
        bus.flush    = 1'b0;
    endtask

    task automatic readPorts(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_en        = 2'b11;
        bus.rd_addr[4:0] = a0;
        bus.rd_addr[9:5] = a1;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        readPorts(5'd5, 5'd31);
        #1;
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", bus.busy_cnt); end
        checks++; if (bus.rd_data !== 64'd0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", bus.rd_data); end
        checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy got %b want 00", bus.rd_busy); end
        checks++; if (bus.rd_tag !== 8'd0) begin errors++; $display("[TB] FAIL reset_tag got %h want 0", bus.rd_tag); end
    endtask

    task automatic test_issue_commit();
        clearInputs();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd5; bus.iss_tag = 4'd3;
        tick();
        clearInputs();
        readPorts(5'd5, 5'd0);
        #1;
        checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL issue_busy got %b want 1", bus.rd_busy[0]); end
        checks++; if (bus.rd_tag[3:0] !== 4'd3) begin errors++; $display("[TB] FAIL issue_tag got %0d want 3", bus.rd_tag[3:0]); end
        checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("[TB] FAIL issue_cnt got %0d want 1", bus.busy_cnt); end
        bus.cmt_en = 1'b1; bus.cmt_addr = 5'd5; bus.cmt_tag = 4'd3; bus.cmt_data = 32'hDEAD0001;
        #1;
        checks++; if (bus.rd_data[31:0] !== 32'hDEAD0001) begin errors++; $display("[TB] FAIL bypass_data got %h want DEAD0001", bus.rd_data[31:0]); end
        checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("[TB] FAIL bypass_busy got %b want 0", bus.rd_busy[0]); end
        checks++; if (bus.rd_data[63:32] !== 32'd0) begin errors++; $display("[TB] FAIL x0_port1 got %h want 0", bus.rd_data[63:32]); end
        tick();
        clearInputs();
        readPorts(5'd5, 5'd5);
        #1;
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("[TB] FAIL commit_cnt got %0d want 0", bus.busy_cnt); end
        checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("[TB] FAIL commit_busy got %b want 00", bus.rd_busy); end
        checks++; if (bus.rd_data !== {32'hDEAD0001, 32'hDEAD0001}) begin errors++; $display("[TB] FAIL commit_data got %h want both DEAD0001", bus.rd_data); end
    endtask

    task automatic test_stale_commit();
        clearInputs();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7; bus.iss_tag = 4'd2;
        tick();
        clearInputs();
        bus.cmt_en = 1'b1; bus.cmt_addr = 5'd7; bus.cmt_tag = 4'd1; bus.cmt_data = 32'h55;
        readPorts(5'd7, 5'd0);
        #1;
        checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL stale_bypass_busy got %b want 1", bus.rd_busy[0]); end
        tick();
        clearInputs();
        readPorts(5'd7, 5'd0);
        #1;
        checks++; if (bus.rd_data[31:0] !== 32'h55) begin errors++; $display("[TB] FAIL stale_data got %h want 55", bus.rd_data[31:0]); end
        checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL stale_busy got %b want 1", bus.rd_busy[0]); end
        checks++; if (bus.rd_tag[3:0] !== 4'd2) begin errors++; $display("[TB] FAIL stale_tag got %0d want 2", bus.rd_tag[3:0]); end
        checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("[TB] FAIL stale_cnt got %0d want 1", bus.busy_cnt); end
        // Release x7 with the right tag so later counts start from zero.
        bus.cmt_en = 1'b1; bus.cmt_addr = 5'd7; bus.cmt_tag = 4'd2; bus.cmt_data = 32'h55;
        tick();
        clearInputs();
        #1;
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("[TB] FAIL release_cnt got %0d want 0", bus.busy_cnt); end
    endtask

    task automatic test_same_cycle();
        clearInputs();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9; bus.iss_tag = 4'd4;
        tick();
        clearInputs();
        bus.cmt_en = 1'b1; bus.cmt_addr = 5'd9; bus.cmt_tag = 4'd4; bus.cmt_data = 32'h0000_1234;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9; bus.iss_tag = 4'd6;
        tick();
        clearInputs();
        readPorts(5'd9, 5'd0);
        #1;
        checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL same_busy got %b want 1", bus.rd_busy[0]); end
        checks++; if (bus.rd_tag[3:0] !== 4'd6) begin errors++; $display("[TB] FAIL same_tag got %0d want 6", bus.rd_tag[3:0]); end
        checks++; if (bus.rd_data[31:0] !== 32'h0000_1234) begin errors++; $display("[TB] FAIL same_data got %h want 00001234", bus.rd_data[31:0]); end
        checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("[TB] FAIL same_cnt got %0d want 1", bus.busy_cnt); end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 10; i++) begin
            clearInputs();
            bus.iss_en = 1'b1; bus.iss_addr = 5'(i); bus.iss_tag = 4'(i);
            tick();
        end
        clearInputs();
        #1;
        checks++; if (bus.busy_cnt !== 6'd10) begin errors++; $display("[TB] FAIL pre_flush_cnt got %0d want 10", bus.busy_cnt); end
        bus.flush  = 1'b1;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3; bus.iss_tag = 4'd9;
        bus.cmt_en = 1'b1; bus.cmt_addr = 5'd2; bus.cmt_tag = 4'd7; bus.cmt_data = 32'hAA;
        tick();
        clearInputs();
        readPorts(5'd3, 5'd5);
        #1;
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("[TB] FAIL flush_cnt got %0d want 0", bus.busy_cnt); end
        checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("[TB] FAIL flush_busy got %b want 00", bus.rd_busy); end
        checks++; if (bus.rd_tag !== 8'd0) begin errors++; $display("[TB] FAIL flush_tag got %h want 0", bus.rd_tag); end
        checks++; if (bus.rd_data[63:32] !== 32'hDEAD0001) begin errors++; $display("[TB] FAIL flush_keep_x5 got %h want DEAD0001", bus.rd_data[63:32]); end
        readPorts(5'd2, 5'd9);
        #1;
        checks++; if (bus.rd_data[31:0] !== 32'hAA) begin errors++; $display("[TB] FAIL flush_commit_x2 got %h want AA", bus.rd_data[31:0]); end
        checks++; if (bus.rd_data[63:32] !== 32'h0000_1234) begin errors++; $display("[TB] FAIL flush_keep_x9 got %h want 00001234", bus.rd_data[63:32]); end
    endtask

    task automatic test_x0();
        clearInputs();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0; bus.iss_tag = 4'd5;
        bus.cmt_en = 1'b1; bus.cmt_addr = 5'd0; bus.cmt_tag = 4'd5; bus.cmt_data = 32'hFFFF_FFFF;
        readPorts(5'd0, 5'd0);
        #1;
        checks++; if (bus.rd_data[31:0] !== 32'd0) begin errors++; $display("[TB] FAIL x0_bypass got %h want 0", bus.rd_data[31:0]); end
        tick();
        clearInputs();
        readPorts(5'd0, 5'd0);
        #1;
        checks++; if ({bus.rd_data, bus.rd_busy, bus.rd_tag} !== 74'd0) begin errors++; $display("[TB] FAIL x0_read got %h/%b/%h want 0/0/0", bus.rd_data, bus.rd_busy, bus.rd_tag); end
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("[TB] FAIL x0_cnt got %0d want 0", bus.busy_cnt); end
        // Disabled port returns zero even for a register holding data.
        bus.rd_en = 2'b01; bus.rd_addr[9:5] = 5'd5;
        #1;
        checks++; if (bus.rd_data[63:32] !== 32'd0) begin errors++; $display("[TB] FAIL rd_en_off got %h want 0", bus.rd_data[63:32]); end
    endtask

    task automatic test_rdy_reset();
        clearInputs();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd12; bus.iss_tag = 4'd1;
        tick();
        clearInputs();
        bus.rdy    = 1'b0;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd13; bus.iss_tag = 4'd5;
        bus.cmt_en = 1'b1; bus.cmt_addr = 5'd5; bus.cmt_tag = 4'd0; bus.cmt_data = 32'hBEEF;
        bus.flush  = 1'b1;
        tick();
        clearInputs();
        bus.rdy = 1'b0;
        readPorts(5'd12, 5'd5);
        #1;
        checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("[TB] FAIL rdy_cnt got %0d want 1", bus.busy_cnt); end
        checks++; if (bus.rd_busy[0] !== 1'b1 || bus.rd_tag[3:0] !== 4'd1) begin errors++; $display("[TB] FAIL rdy_x12 got busy=%b tag=%0d want 1/1", bus.rd_busy[0], bus.rd_tag[3:0]); end
        checks++; if (bus.rd_data[63:32] !== 32'hDEAD0001) begin errors++; $display("[TB] FAIL rdy_x5 got %h want DEAD0001", bus.rd_data[63:32]); end
        readPorts(5'd13, 5'd5);
        #1;
        checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("[TB] FAIL rdy_x13 got %b want 0", bus.rd_busy[0]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        readPorts(5'd12, 5'd5);
        #1;
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("[TB] FAIL rst_cnt got %0d want 0", bus.busy_cnt); end
        checks++; if (bus.rd_busy !== 2'b00 || bus.rd_tag !== 8'd0) begin errors++; $display("[TB] FAIL rst_busy got %b/%h want 00/0", bus.rd_busy, bus.rd_tag); end
        checks++; if (bus.rd_data !== 64'd0) begin errors++; $display("[TB] FAIL rst_data got %h want 0", bus.rd_data); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        clearInputs();
        test_reset();
        test_issue_commit();
        test_stale_commit();
        test_same_cycle();
        test_flush();
        test_x0();
        test_rdy_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
